roberto_cmd_serial: RTL

Serial command decoder for the servo stage. It consumes 7-bit ASCII characters from the UART receiver (`dado_recebido` / `pronto_recepcao`) and assembles frames of the form `S<id><c><d><u>#`. It validates each frame, range-checks the angle, and holds one 8-bit angle register per servo (1–3) for the PWM generators downstream. Malformed frames, out-of-range values and stalled frames are discarded with an error pulse.

---
 rtl/roberto_cmd_serial.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/roberto_cmd_serial.sv
// rtl/roberto_cmd_serial.sv - serial "S<id><c><d><u>#" command decoder holding three servo angles
//
// Ports:
//   clock            in   1  rising-edge clock
//   reset            in   1  asynchronous active-low reset
//   dado_recebido    in   7  ASCII character, valid with pronto_recepcao
//   pronto_recepcao  in   1  one-cycle character strobe
//   posicao1..3      out  8  angle registers, 0..ANGULO_MAX
//   atualizado       out  1  one-cycle pulse after an angle register write
//   servo_atualizado out  2  id of the last servo written, 0 after reset
//   erro             out  1  one-cycle pulse after a rejected frame
//   db_estado        out  4  current FSM state code
module roberto_cmd_serial #(
    parameter int TIMEOUT_CICLOS = 50_000_000,
    parameter int ANGULO_MAX     = 180,
    parameter int ANGULO_RESET   = 90
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] dado_recebido,
    input  logic       pronto_recepcao,
    output logic [7:0] posicao1,
    output logic [7:0] posicao2,
    output logic [7:0] posicao3,
    output logic       atualizado,
    output logic [1:0] servo_atualizado,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam int CW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ID      = 4'd1,
        CENTENA = 4'd2,
        DEZENA  = 4'd3,
        UNIDADE = 4'd4,
        FIM     = 4'd5,
        GRAVA   = 4'd6,
        ERRO    = 4'd7
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [9:0]    acc_q, acc_d;
    logic [1:0]    id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    pos1_q, pos2_q, pos3_q;
    logic [1:0]    servo_q;
    logic          grava;

    logic is_s, is_dig, is_id, is_fim, em_quadro, expira, na_faixa;

    assign is_s      = (dado_recebido == 7'h53);
    assign is_dig    = (dado_recebido >= 7'h30) && (dado_recebido <= 7'h39);
    assign is_id     = (dado_recebido >= 7'h31) && (dado_recebido <= 7'h33);
    assign is_fim    = (dado_recebido == 7'h23);
    assign em_quadro = (estado_q >= ID) && (estado_q <= FIM);
    assign na_faixa  = (acc_q <= 10'(ANGULO_MAX));
    // The count reaches TIMEOUT_CICLOS-1 on this edge.
    assign expira    = (cnt_q == CW'(TIMEOUT_CICLOS - 2));

    always_comb begin
        estado_d = estado_q;
        acc_d    = acc_q;
        id_d     = id_q;
        grava    = 1'b0;
        cnt_d    = '0;

        // A strobe always wins over the timeout on the same edge.
        if (em_quadro && !pronto_recepcao) begin
            if (expira) begin
                estado_d = ERRO;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (estado_q)
            IDLE, GRAVA, ERRO: begin
                if (pronto_recepcao && is_s) begin
                    estado_d = ID;
                end else begin
                    estado_d = IDLE;
                end
            end
            ID: begin
                if (pronto_recepcao) begin
                    if (is_id) begin
                        id_d     = dado_recebido[1:0];
                        acc_d    = '0;
                        estado_d = CENTENA;
                    end else begin
                        estado_d = ERRO;
                    end
                end
            end
            CENTENA, DEZENA, UNIDADE: begin
                if (pronto_recepcao) begin
                    if (is_dig) begin
                        acc_d    = acc_q * 10'd10 + {6'd0, dado_recebido[3:0]};
                        estado_d = estado_t'(estado_q + 4'd1);
                    end else begin
                        estado_d = ERRO;
                    end
                end
            end
            FIM: begin
                if (pronto_recepcao) begin
                    if (is_fim && na_faixa) begin
                        grava    = 1'b1;
                        estado_d = GRAVA;
                    end else begin
                        estado_d = ERRO;
                    end
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= IDLE;
            acc_q    <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            pos1_q   <= 8'(ANGULO_RESET);
            pos2_q   <= 8'(ANGULO_RESET);
            pos3_q   <= 8'(ANGULO_RESET);
            servo_q  <= '0;
        end else begin
            estado_q <= estado_d;
            acc_q    <= acc_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            if (grava) begin
                servo_q <= id_q;
                case (id_q)
                    2'd1:    pos1_q <= acc_q[7:0];
                    2'd2:    pos2_q <= acc_q[7:0];
                    2'd3:    pos3_q <= acc_q[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign posicao1         = pos1_q;
    assign posicao2         = pos2_q;
    assign posicao3         = pos3_q;
    assign servo_atualizado = servo_q;
    assign atualizado       = (estado_q == GRAVA);
    assign erro             = (estado_q == ERRO);
    assign db_estado        = estado_q;

endmodule
